// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter sharing one word-wide memory port
module mem_arbiter_rr #(
  parameter int         M_WIDTH      = 32,
  parameter int         CLIENT_CNT   = 2,
  parameter int         READ_LATENCY = 1,
  parameter logic [1:0] MEM_ACC_8    = 2'b00,
  parameter logic [1:0] MEM_ACC_16   = 2'b01,
  parameter logic [1:0] MEM_ACC_32   = 2'b10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CLIENT_CNT-1:0]                 client_reqs,
  input  logic [M_WIDTH*CLIENT_CNT-1:0]         client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]                 client_wes,
  input  logic [2*CLIENT_CNT-1:0]               client_widths_packed,
  input  logic [M_WIDTH*CLIENT_CNT-1:0]         client_data_outs_packed,
  output logic [CLIENT_CNT-1:0]                 client_readies,
  output logic [CLIENT_CNT-1:0]                 client_errs,
  output logic [M_WIDTH-1:0]                    client_data_in,
  input  logic [M_WIDTH-1:0]                    mem_data_in,
  output logic [M_WIDTH-1:0]                    mem_data_out,
  output logic [M_WIDTH-$clog2(M_WIDTH/8)-1:0]  mem_addr,
  output logic [M_WIDTH/8-1:0]                  mem_wes,
  output logic                                  busy
);

  localparam int BYTES = M_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int GW    = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;
  localparam int CW    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state, state_next;
  logic [GW-1:0]      ptr, grant, arb_sel;
  logic               arb_found;
  logic [M_WIDTH-1:0] sel_addr, sel_data, read_aligned;
  logic [1:0]         sel_width, width_q;
  logic               sel_we, sel_err, we_q, err_q;
  logic [OFF_W-1:0]   sel_off, off_q;
  logic [CW-1:0]      cnt;
  logic               last_cycle;

  // Rotating priority search: first requester after the last grant, wrapping around.
  always_comb begin
    arb_sel   = ptr;
    arb_found = 1'b0;
    for (int i = 1; i <= CLIENT_CNT; i++) begin
      if (!arb_found && client_reqs[(int'(ptr) + i) % CLIENT_CNT]) begin
        arb_sel   = GW'((int'(ptr) + i) % CLIENT_CNT);
        arb_found = 1'b1;
      end
    end
  end

  assign sel_addr   = client_addrs_packed[int'(arb_sel)*M_WIDTH +: M_WIDTH];
  assign sel_data   = client_data_outs_packed[int'(arb_sel)*M_WIDTH +: M_WIDTH];
  assign sel_width  = client_widths_packed[int'(arb_sel)*2 +: 2];
  assign sel_we     = client_wes[arb_sel];
  assign sel_off    = sel_addr[OFF_W-1:0];
  assign last_cycle = (cnt == CW'(READ_LATENCY));

  // Misalignment and unknown width codes are rejected before touching memory.
  always_comb begin
    case (sel_width)
      MEM_ACC_8:  sel_err = 1'b0;
      MEM_ACC_16: sel_err = sel_addr[0];
      MEM_ACC_32: sel_err = |sel_off;
      default:    sel_err = 1'b1;
    endcase
  end

  // Read return: shift the addressed bytes down to bit 0 and clear unused upper bits.
  always_comb begin
    read_aligned = mem_data_in >> (8 * off_q);
    if (width_q == MEM_ACC_8) begin
      read_aligned[M_WIDTH-1:8] = '0;
    end else if (width_q == MEM_ACC_16) begin
      read_aligned[M_WIDTH-1:16] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state outputs; write lanes fire only on the first access cycle.
  always_comb begin
    state_next     = state;
    busy           = (state != IDLE);
    client_readies = '0;
    client_errs    = '0;
    mem_wes        = '0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_next = sel_err ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0 && we_q) begin
          case (width_q)
            MEM_ACC_8:  mem_wes = BYTES'(1) << off_q;
            MEM_ACC_16: mem_wes = BYTES'(3) << off_q;
            default:    mem_wes = '1;
          endcase
        end
        if (last_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        client_readies[grant] = 1'b1;
        client_errs[grant]    = err_q;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant capture, memory port registers, latency counter and read-data sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= GW'(CLIENT_CNT - 1);
      grant          <= '0;
      width_q        <= '0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      off_q          <= '0;
      cnt            <= '0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      client_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            ptr     <= arb_sel;
            grant   <= arb_sel;
            width_q <= sel_width;
            we_q    <= sel_we;
            err_q   <= sel_err;
            off_q   <= sel_off;
            cnt     <= '0;
            if (sel_err) begin
              client_data_in <= '0;
            end else begin
              mem_addr     <= sel_addr[M_WIDTH-1:OFF_W];
              mem_data_out <= sel_data << (8 * sel_off);
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_cycle) begin
            client_data_in <= read_aligned;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr
module tb_mem_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  logic [1:0]  reqs = '0, reqs3 = '0, wes_in = '0;
  logic [63:0] addrs = '0, wdata = '0;
  logic [3:0]  widths = '0;

  logic [1:0]  readies1, errs1, readies3, errs3;
  logic [31:0] rdata1, rdata3, mem_rdata1, mem_rdata3, mem_wdata1, mem_wdata3;
  logic [29:0] mem_addr1, mem_addr3;
  logic [3:0]  mem_wes1, mem_wes3;
  logic        busy1, busy3;

  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];
  logic [31:0] rd1;
  logic [31:0] pipe3 [0:2];

  int          n_checks = 0;
  int          n_fail = 0;
  int          wes_cnt = 0;
  logic [3:0]  wes_last = '0;

  typedef struct {
    int          client;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          client;
    logic        we;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  widx;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  exp_wes;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs [0:11];

  mem_arbiter_rr #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .client_reqs(reqs), .client_addrs_packed(addrs),
    .client_wes(wes_in), .client_widths_packed(widths), .client_data_outs_packed(wdata),
    .client_readies(readies1), .client_errs(errs1), .client_data_in(rdata1),
    .mem_data_in(mem_rdata1), .mem_data_out(mem_wdata1), .mem_addr(mem_addr1),
    .mem_wes(mem_wes1), .busy(busy1)
  );

  mem_arbiter_rr #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .client_reqs(reqs3), .client_addrs_packed(addrs),
    .client_wes(wes_in), .client_widths_packed(widths), .client_data_outs_packed(wdata),
    .client_readies(readies3), .client_errs(errs3), .client_data_in(rdata3),
    .mem_data_in(mem_rdata3), .mem_data_out(mem_wdata3), .mem_addr(mem_addr3),
    .mem_wes(mem_wes3), .busy(busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: byte-lane writes, preload port, read latency 1 and 3.
  always @(posedge clk) begin
    if (pre_en) begin
      mem1[pre_idx] <= pre_val;
      mem3[pre_idx] <= pre_val;
    end
    for (int b = 0; b < 4; b++) begin
      if (mem_wes1[b]) mem1[mem_addr1[3:0]][8*b +: 8] <= mem_wdata1[8*b +: 8];
      if (mem_wes3[b]) mem3[mem_addr3[3:0]][8*b +: 8] <= mem_wdata3[8*b +: 8];
    end
    rd1      <= mem1[mem_addr1[3:0]];
    pipe3[0] <= mem3[mem_addr3[3:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata1 = rd1;
  assign mem_rdata3 = pipe3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (mem_wes1 != 4'h0) begin
      wes_cnt++;
      wes_last = mem_wes1;
    end
    if (!rst && readies1 != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {30'd0, readies1}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_client", {30'd0, readies1}, 32'd1 << e.client);
        check("err_flag", {30'd0, errs1}, e.err ? (32'd1 << e.client) : 32'd0);
        if (e.chk_data) check("read_data", rdata1, e.data);
        check("ready_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic push(input int c, input logic [31:0] d, input logic err, input logic chk, input int cy);
    exp_t e;
    e.client = c; e.data = d; e.err = err; e.chk_data = chk; e.cyc = cy;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      check("ready_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic drive(input int c, input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    addrs[c*32 +: 32] = a;
    wdata[c*32 +: 32] = d;
    widths[c*2 +: 2]  = w;
    wes_in[c]         = we;
    reqs[c]           = 1'b1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    step();
    pre_en  = 1'b0;
  endtask

  initial begin
    int t, wes_before;
    vecs[0]  = '{1, 1'b0, 2'b10, 32'h10, 32'h0,      4'd4, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'h0, 32'hDEADBEEF};
    vecs[1]  = '{0, 1'b1, 2'b00, 32'h07, 32'hA5,     4'd1, 32'h11223344, 32'h0,        1'b0, 4'h8, 32'hA5223344};
    vecs[2]  = '{0, 1'b0, 2'b01, 32'h06, 32'h0,      4'd1, 32'h12345678, 32'h00001234, 1'b0, 4'h0, 32'h12345678};
    vecs[3]  = '{1, 1'b0, 2'b00, 32'h09, 32'h0,      4'd2, 32'hCAFEF00D, 32'h000000F0, 1'b0, 4'h0, 32'hCAFEF00D};
    vecs[4]  = '{0, 1'b1, 2'b01, 32'h02, 32'hBEEF,   4'd0, 32'h11223344, 32'h0,        1'b0, 4'hC, 32'hBEEF3344};
    vecs[5]  = '{1, 1'b1, 2'b10, 32'h0C, 32'h0BADC0DE, 4'd3, 32'h0,      32'h0,        1'b0, 4'hF, 32'h0BADC0DE};
    vecs[6]  = '{0, 1'b1, 2'b01, 32'h03, 32'hFFFF,   4'd0, 32'h55555555, 32'h0,        1'b1, 4'h0, 32'h55555555};
    vecs[7]  = '{1, 1'b0, 2'b10, 32'h02, 32'h0,      4'd0, 32'h55555555, 32'h0,        1'b1, 4'h0, 32'h55555555};
    vecs[8]  = '{0, 1'b0, 2'b11, 32'h00, 32'h0,      4'd0, 32'h55555555, 32'h0,        1'b1, 4'h0, 32'h55555555};
    vecs[9]  = '{1, 1'b0, 2'b01, 32'h05, 32'h0,      4'd1, 32'h12345678, 32'h0,        1'b1, 4'h0, 32'h12345678};
    vecs[10] = '{1, 1'b0, 2'b01, 32'h02, 32'h0,      4'd0, 32'hA1B2C3D4, 32'h0000A1B2, 1'b0, 4'h0, 32'hA1B2C3D4};
    vecs[11] = '{0, 1'b0, 2'b00, 32'h03, 32'h0,      4'd0, 32'hA1B2C3D4, 32'h000000A1, 1'b0, 4'h0, 32'hA1B2C3D4};

    // Reset state.
    step(); step(); step();
    check("reset_busy", {31'd0, busy1}, 32'd0);
    check("reset_readies", {30'd0, readies1}, 32'd0);
    check("reset_errs", {30'd0, errs1}, 32'd0);
    check("reset_wes", {28'd0, mem_wes1}, 32'd0);
    check("reset_addr", {2'd0, mem_addr1}, 32'd0);
    check("reset_rdata", rdata1, 32'd0);
    check("reset_wdata", mem_wdata1, 32'd0);
    rst = 1'b0;

    // Single-client vectors.
    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].widx, vecs[i].pre);
      check("busy_idle", {31'd0, busy1}, 32'd0);
      wes_before = wes_cnt;
      drive(vecs[i].client, vecs[i].we, vecs[i].w, vecs[i].addr, vecs[i].wdata);
      t = cyc;
      push(vecs[i].client, vecs[i].exp_rd, vecs[i].exp_err, !vecs[i].we || vecs[i].exp_err,
           t + (vecs[i].exp_err ? 1 : 3));
      step();
      if (!vecs[i].exp_err) check("mem_addr", {2'd0, mem_addr1}, vecs[i].addr >> 2);
      drain(10);
      reqs = '0;
      check("wes_pulses", wes_cnt - wes_before, (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
      if (vecs[i].we && !vecs[i].exp_err) check("wes_lanes", {28'd0, wes_last}, {28'd0, vecs[i].exp_wes});
      step();
      check("mem_word", mem1[vecs[i].widx], vecs[i].exp_word);
    end

    // Both clients request continuously after reset: grants alternate 0,1,0,1.
    preload(4'd0, 32'h01020304);
    preload(4'd4, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 2'b10, 32'h00, 32'h0);
    drive(1, 1'b0, 2'b10, 32'h10, 32'h0);
    t = cyc;
    push(0, 32'h01020304, 1'b0, 1'b1, t + 3);
    push(1, 32'hDEADBEEF, 1'b0, 1'b1, t + 7);
    push(0, 32'h01020304, 1'b0, 1'b1, t + 11);
    push(1, 32'hDEADBEEF, 1'b0, 1'b1, t + 15);
    drain(30);
    reqs = '0;
    for (int k = 0; k < 6; k++) step();

    // Reset during a write access aborts it; pointer returns to favour client 0.
    drive(0, 1'b1, 2'b10, 32'h08, 32'h11111111);
    step();
    check("abort_wes_c0", {28'd0, mem_wes1}, 32'hF);
    rst = 1'b1;
    step();
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_wes", {28'd0, mem_wes1}, 32'd0);
    check("abort_ready", {30'd0, readies1}, 32'd0);
    check("abort_err", {30'd0, errs1}, 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 2'b10, 32'h00, 32'h0);
    drive(1, 1'b0, 2'b10, 32'h10, 32'h0);
    t = cyc;
    push(0, 32'h01020304, 1'b0, 1'b1, t + 3);
    push(1, 32'hDEADBEEF, 1'b0, 1'b1, t + 7);
    drain(20);
    reqs = '0;
    for (int k = 0; k < 4; k++) step();

    // READ_LATENCY=3: address held four cycles, data captured on the last one.
    preload(4'd0, 32'h00000000);
    preload(4'd5, 32'h89ABCDEF);
    addrs[31:0]  = 32'h14;
    widths[1:0]  = 2'b10;
    wes_in[0]    = 1'b0;
    reqs3        = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rl3_addr", {2'd0, mem_addr3}, 32'd5);
      check("rl3_early_ready", {30'd0, readies3}, 32'd0);
    end
    step();
    check("rl3_ready", {30'd0, readies3}, 32'd1);
    check("rl3_err", {30'd0, errs3}, 32'd0);
    check("rl3_data", rdata3, 32'h89ABCDEF);
    reqs3 = '0;
    step();
    check("rl3_idle", {31'd0, busy3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
